// File: rtl/truth_table_equiv_checker_if.sv
// Bundle of the request, result and trace-stream signals of the truth-table
// equivalence checker. The checker uses the slave view and the driver uses the master view.
interface truth_table_equiv_checker_if #(
   parameter int N_VARS = 4
);
   localparam int TW = 1 << N_VARS;

   logic              start;
   logic [TW-1:0]     table_a;
   logic [TW-1:0]     table_b;
   logic              pol_a;
   logic              pol_b;
   logic              stop_on_fail;

   logic              busy;
   logic              done;
   logic              equal;
   logic [N_VARS:0]   mismatch_count;
   logic [N_VARS-1:0] first_fail;
   logic              first_fail_valid;

   logic              trace_valid;
   logic              trace_ready;
   logic [N_VARS-1:0] trace_vec;
   logic              trace_fa;
   logic              trace_fb;
   logic              trace_miss;

   modport master (
      output start, table_a, table_b, pol_a, pol_b, stop_on_fail, trace_ready,
      input  busy, done, equal, mismatch_count, first_fail, first_fail_valid,
      input  trace_valid, trace_vec, trace_fa, trace_fb, trace_miss
   );

   modport slave (
      input  start, table_a, table_b, pol_a, pol_b, stop_on_fail, trace_ready,
      output busy, done, equal, mismatch_count, first_fail, first_fail_valid,
      output trace_valid, trace_vec, trace_fa, trace_fb, trace_miss
   );
endinterface

// File: rtl/truth_table_equiv_checker.sv
// Sequential equivalence checker: walks every input vector of two N-variable
// truth tables, one vector per accepted trace beat. It counts the mismatches,
// remembers the first failing vector and streams each evaluation out.
module truth_table_equiv_checker #(
   parameter int N_VARS = 4
) (
   input logic                     clk,
   input logic                     reset,
   truth_table_equiv_checker_if.slave bus
);
   localparam int                TW       = 1 << N_VARS;
   localparam logic [N_VARS-1:0] LAST_VEC = '1;
   localparam logic [N_VARS-1:0] IDX_ONE  = N_VARS'(1);
   localparam logic [N_VARS:0]   CNT_ONE  = (N_VARS + 1)'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   state_t            state_next;

   logic [TW-1:0]     lat_a;
   logic [TW-1:0]     lat_b;
   logic              lat_pol_a;
   logic              lat_pol_b;
   logic              lat_stop;

   logic [N_VARS-1:0] index;
   logic [N_VARS:0]   miss_count;
   logic [N_VARS-1:0] fail_vec;
   logic              fail_valid;
   logic              equal_q;

   logic              in_run;
   logic              accept;
   logic              fa;
   logic              fb;
   logic              miss;
   logic              xfer;
   logic              last_beat;

   // A set polarity bit means the mask lists maxterms, so the function value is inverted
   assign in_run    = (state == RUN);
   assign accept    = (state == IDLE) && bus.start;
   assign fa        = lat_a[index] ^ lat_pol_a;
   assign fb        = lat_b[index] ^ lat_pol_b;
   assign miss      = fa ^ fb;
   assign xfer      = in_run && bus.trace_ready;
   assign last_beat = (index == LAST_VEC) || (miss && lat_stop);

   // The trace fields are forced to zero outside RUN so that idle beats read clean
   assign bus.trace_valid      = in_run;
   assign bus.trace_vec        = in_run ? index : '0;
   assign bus.trace_fa         = in_run & fa;
   assign bus.trace_fb         = in_run & fb;
   assign bus.trace_miss       = in_run & miss;
   assign bus.busy             = (state != IDLE);
   assign bus.done             = (state == DONE);
   assign bus.equal            = equal_q;
   assign bus.mismatch_count   = miss_count;
   assign bus.first_fail       = fail_vec;
   assign bus.first_fail_valid = fail_valid;

   // State register; reset abandons any sweep in progress without a done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: RUN lasts until the final beat transfers, and DONE lasts one cycle
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.start) state_next = RUN;
         RUN:  if (xfer && last_beat) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: latch the job when it starts, then advance and accumulate only on transferred beats
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_a      <= '0;
         lat_b      <= '0;
         lat_pol_a  <= 1'b0;
         lat_pol_b  <= 1'b0;
         lat_stop   <= 1'b0;
         index      <= '0;
         miss_count <= '0;
         fail_vec   <= '0;
         fail_valid <= 1'b0;
         equal_q    <= 1'b0;
      end else if (accept) begin
         lat_a      <= bus.table_a;
         lat_b      <= bus.table_b;
         lat_pol_a  <= bus.pol_a;
         lat_pol_b  <= bus.pol_b;
         lat_stop   <= bus.stop_on_fail;
         index      <= '0;
         miss_count <= '0;
         fail_vec   <= '0;
         fail_valid <= 1'b0;
         equal_q    <= 1'b0;
      end else if (xfer) begin
         if (miss) begin
            miss_count <= miss_count + CNT_ONE;
            if (!fail_valid) begin
               fail_vec   <= index;
               fail_valid <= 1'b1;
            end
         end
         if (last_beat) begin
            equal_q <= (miss_count == '0) && !miss;
         end else begin
            index <= index + IDX_ONE;
         end
      end
   end
endmodule

// File: tb/tb_truth_table_equiv_checker.sv
// Self-checking bench for truth_table_equiv_checker (N_VARS = 4). It runs directed
// and random sweeps. The expected results come from a whole-table evaluation of
// both functions.
module tb_truth_table_equiv_checker;
   localparam int N = 4;
   localparam int TW = 1 << N;

   logic clk = 1'b0;
   logic reset;
   int   check_count = 0;
   int   pass_count  = 0;
   int   fail_count  = 0;

   truth_table_equiv_checker_if #(.N_VARS(N)) bus ();

   truth_table_equiv_checker #(.N_VARS(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock with a period of 10 time units
   always #5 clk = ~clk;

   // Each comparison counts as one check; a failure is reported and the run continues
   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Function value of vector i: a minterm list gives the bit itself, a maxterm list gives its complement
   function automatic logic f_of(input logic [TW-1:0] t, input logic p, input int i);
      if (p) return ~t[i];
      return t[i];
   endfunction

   // Runs one sweep. The bench stalls trace_ready at stall_vec for stall_len cycles and
   // adds random stalls at rand_pct percent. When reset_vec is non-negative, it pulses
   // reset at that vector. When poke is set, it re-raises start mid-sweep with scrambled inputs.
   task automatic apply_stimulus(input string name, input logic [TW-1:0] ta, input logic [TW-1:0] tbm,
                                 input logic pa, input logic pb, input logic sof,
                                 input int stall_vec, input int stall_len, input int rand_pct,
                                 input int reset_vec, input bit poke);
      int exp_count, exp_first, beats, idx, edges, stalls, stalled_here, guard;
      bit have_fail, finished, ready;
      exp_count = 0; exp_first = 0; have_fail = 0;
      for (int i = 0; i < TW; i++) begin
         if (f_of(ta, pa, i) !== f_of(tbm, pb, i)) begin
            if (!have_fail) begin
               have_fail = 1;
               exp_first = i;
            end
            exp_count++;
         end
      end
      beats = TW;
      if (sof && have_fail) begin
         beats = exp_first + 1;
         exp_count = 1;
      end
      $display("[TB] sweep %s", name);

      @(negedge clk);
      bus.table_a = ta; bus.table_b = tbm; bus.pol_a = pa; bus.pol_b = pb;
      bus.stop_on_fail = sof; bus.start = 1'b1; bus.trace_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.table_a = TW'($urandom); bus.table_b = TW'($urandom);
      bus.pol_a = 1'($urandom); bus.pol_b = 1'($urandom); bus.stop_on_fail = 1'($urandom);

      idx = 0; edges = 0; stalls = 0; stalled_here = 0; guard = 0; finished = 0;
      while (!finished && guard < 2000) begin
         guard++;
         check_output({name, " valid"}, bus.trace_valid, 1);
         check_output({name, " vec"},   bus.trace_vec, idx);
         check_output({name, " fa"},    bus.trace_fa, f_of(ta, pa, idx));
         check_output({name, " fb"},    bus.trace_fb, f_of(tbm, pb, idx));
         check_output({name, " miss"},  bus.trace_miss, f_of(ta, pa, idx) ^ f_of(tbm, pb, idx));
         check_output({name, " busy"},  bus.busy, 1);
         check_output({name, " done"},  bus.done, 0);
         if (idx == reset_vec) begin
            reset = 1'b1;
            #1;
            check_output({name, " rst busy"},  bus.busy, 0);
            check_output({name, " rst valid"}, bus.trace_valid, 0);
            check_output({name, " rst vec"},   bus.trace_vec, 0);
            check_output({name, " rst count"}, bus.mismatch_count, 0);
            check_output({name, " rst ffv"},   bus.first_fail_valid, 0);
            check_output({name, " rst done"},  bus.done, 0);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check_output({name, " post-rst busy"}, bus.busy, 0);
            check_output({name, " post-rst done"}, bus.done, 0);
            return;
         end
         if (poke && idx == 3) begin
            bus.start = 1'b1;
            bus.table_a = TW'($urandom); bus.table_b = TW'($urandom);
         end
         if (idx == stall_vec && stalled_here < stall_len) begin
            ready = 0;
            stalled_here++;
         end else if (rand_pct > 0 && int'($urandom_range(0, 99)) < rand_pct) begin
            ready = 0;
         end else begin
            ready = 1;
         end
         if (!ready) stalls++;
         bus.trace_ready = ready;
         @(posedge clk);
         edges++;
         if (ready) begin
            if (idx == beats - 1) finished = 1;
            else idx++;
         end
         @(negedge clk);
         bus.start = 1'b0;
      end
      bus.trace_ready = 1'b1;
      if (!finished) begin
         check_count++;
         fail_count++;
         $error("[TB] FAIL %s timeout: observed no completion, expected done within 2000 cycles", name);
         return;
      end

      check_output({name, " done"},    bus.done, 1);
      check_output({name, " busy"},    bus.busy, 1);
      check_output({name, " valid0"},  bus.trace_valid, 0);
      check_output({name, " vec0"},    bus.trace_vec, 0);
      check_output({name, " miss0"},   bus.trace_miss, 0);
      check_output({name, " equal"},   bus.equal, exp_count == 0);
      check_output({name, " count"},   bus.mismatch_count, exp_count);
      check_output({name, " first"},   bus.first_fail, exp_first);
      check_output({name, " ffv"},     bus.first_fail_valid, have_fail);
      check_output({name, " latency"}, edges, beats + stalls);
      @(negedge clk);
      check_output({name, " done off"}, bus.done, 0);
      check_output({name, " idle"},     bus.busy, 0);
      check_output({name, " hold cnt"}, bus.mismatch_count, exp_count);
      check_output({name, " hold eq"},  bus.equal, exp_count == 0);
   endtask

   // Directed test-plan sweeps, then random ones, then the summary line
   initial begin
      logic [TW-1:0] ra, rb, mask;
      logic rpa, rpb;
      reset = 1'b1;
      bus.start = 1'b0; bus.table_a = '0; bus.table_b = '0; bus.pol_a = 1'b0; bus.pol_b = 1'b0;
      bus.stop_on_fail = 1'b0; bus.trace_ready = 1'b0;
      #12;
      check_output("reset busy",  bus.busy, 0);
      check_output("reset done",  bus.done, 0);
      check_output("reset equal", bus.equal, 0);
      check_output("reset count", bus.mismatch_count, 0);
      check_output("reset first", bus.first_fail, 0);
      check_output("reset ffv",   bus.first_fail_valid, 0);
      check_output("reset valid", bus.trace_valid, 0);
      check_output("reset vec",   bus.trace_vec, 0);
      @(negedge clk);
      reset = 1'b0;

      apply_stimulus("equal",      16'hC0F0, 16'h3F0F, 1'b1, 1'b0, 1'b0, -1, 0, 0, -1, 0);
      apply_stimulus("one-miss",   16'hC0F0, 16'h3F0E, 1'b1, 1'b0, 1'b0, -1, 0, 0, -1, 0);
      apply_stimulus("all-miss",   16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, -1, 0, 0, -1, 0);
      apply_stimulus("stop-fail",  16'hC0F0, 16'h3F8F, 1'b1, 1'b0, 1'b1, -1, 0, 0, -1, 0);
      apply_stimulus("stall5",     16'hC0F0, 16'h3F0F, 1'b1, 1'b0, 1'b0, 5, 3, 0, -1, 0);
      apply_stimulus("reset-mid",  16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, -1, 0, 0, 9, 0);
      apply_stimulus("start-poke", 16'hC0F0, 16'h3F8E, 1'b1, 1'b0, 1'b0, -1, 0, 0, -1, 1);
      apply_stimulus("max-vec",    16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, -1, 0, 0, -1, 0);

      for (int k = 0; k < 10; k++) begin
         ra   = TW'($urandom);
         rpa  = 1'($urandom);
         rpb  = 1'($urandom);
         case ($urandom_range(0, 2))
            0:       mask = '0;
            1:       mask = TW'(1) << $urandom_range(0, TW - 1);
            default: mask = TW'($urandom);
         endcase
         rb = ((rpa == rpb) ? ra : ~ra) ^ mask;
         apply_stimulus($sformatf("rand%0d", k), ra, rb, rpa, rpb, 1'($urandom), -1, 0, 30, -1, 0);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
